// File: rtl/bingo_board_pkg.sv
// Shared constants, FSM encoding and small arithmetic helpers for the bingo board block.
package bingo_board_pkg;

  localparam int N_CELLS     = 25;
  localparam int CELL_W      = 5;
  localparam int N_LINES     = 12;
  localparam int BINGO_LINES = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [3:0] count_lines(input logic [N_LINES-1:0] lines);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N_LINES; i++) begin
      cnt = cnt + {3'd0, lines[i]};
    end
    return cnt;
  endfunction

  // Line count never exceeds 12, so a single compare against 10 is enough.
  function automatic logic [7:0] to_bcd(input logic [3:0] n);
    if (n >= 4'd10) begin
      return {4'd1, n - 4'd10};
    end
    return {4'd0, n};
  endfunction

endpackage

// File: rtl/bingo_board_line_checker.sv
// Combinational detection of completed rows, columns and both diagonals.
module line_checker
  import bingo_board_pkg::*;
(
  input  logic [N_CELLS-1:0] circle,
  output logic [N_LINES-1:0] line
);

  always_comb begin
    line = '0;
    for (int r = 0; r < 5; r++) begin
      line[r] = &circle[r*5 +: 5];
    end
    for (int c = 0; c < 5; c++) begin
      line[5+c] = 1'b1;
      for (int r = 0; r < 5; r++) begin
        line[5+c] = line[5+c] & circle[c + r*5];
      end
    end
    line[10] = circle[0] & circle[6] & circle[12] & circle[18] & circle[24];
    line[11] = circle[4] & circle[8] & circle[12] & circle[16] & circle[20];
  end

endmodule

// File: rtl/bingo_board.sv
// Bingo board controller: loads a 5x5 board, scans one cell per cycle for a called
// number, marks the first match and recomputes completed lines and the BCD line count.
//
//   state | meaning
//   IDLE  | waiting; accepts a board load or a call
//   SCAN  | comparing cell idx against the latched number
//   COUNT | registering lines, BCD count and bingo from the updated mask
//   DONE  | one-cycle done pulse, then back to IDLE
module bingo_board
  import bingo_board_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [N_CELLS*CELL_W-1:0] load_data,
  input  logic                      call_valid,
  input  logic [CELL_W-1:0]         call_num,
  output logic                      call_ready,
  output logic [N_CELLS*CELL_W-1:0] map,
  output logic [N_CELLS-1:0]        circle,
  output logic [N_LINES-1:0]        line,
  output logic [7:0]                display_nums,
  output logic                      bingo,
  output logic                      done,
  output logic                      found
);

  logic [1:0]                state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic [CELL_W-1:0]         num_q, num_d;
  logic [N_CELLS*CELL_W-1:0] map_q, map_d;
  logic [N_CELLS-1:0]        circle_q, circle_d;
  logic [N_LINES-1:0]        line_q, line_d;
  logic [7:0]                disp_q, disp_d;
  logic                      bingo_q, bingo_d;
  logic                      found_q, found_d;

  logic [N_LINES-1:0] line_w;
  logic [CELL_W-1:0]  cur_cell;
  logic [3:0]         line_cnt;

  line_checker u_line_checker (
    .circle (circle_q),
    .line   (line_w)
  );

  always_comb begin
    cur_cell = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (idx_q == 5'(i)) begin
        cur_cell = map_q[i*CELL_W +: CELL_W];
      end
    end
  end

  assign line_cnt   = count_lines(line_w);
  assign call_ready = (state_q == ST_IDLE) && !load_valid;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    map_d    = map_q;
    circle_d = circle_q;
    line_d   = line_q;
    disp_d   = disp_q;
    bingo_d  = bingo_q;
    found_d  = found_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          map_d    = load_data;
          circle_d = '0;
          line_d   = '0;
          disp_d   = 8'h00;
          bingo_d  = 1'b0;
          found_d  = 1'b0;
        end else if (call_valid) begin
          num_d   = call_num;
          idx_d   = 5'd0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Stopping at the first hit leaves any duplicate at a higher index unmarked.
        if (cur_cell == num_q) begin
          circle_d = circle_q | (25'd1 << idx_q);
          found_d  = 1'b1;
          state_d  = ST_COUNT;
        end else if (idx_q == 5'(N_CELLS-1)) begin
          found_d  = 1'b0;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_COUNT: begin
        line_d  = line_w;
        disp_d  = to_bcd(line_cnt);
        bingo_d = line_cnt >= 4'(BINGO_LINES);
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 5'd0;
      num_q    <= '0;
      map_q    <= '0;
      circle_q <= '0;
      line_q   <= '0;
      disp_q   <= 8'h00;
      bingo_q  <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      map_q    <= map_d;
      circle_q <= circle_d;
      line_q   <= line_d;
      disp_q   <= disp_d;
      bingo_q  <= bingo_d;
      found_q  <= found_d;
    end
  end

  assign map          = map_q;
  assign circle       = circle_q;
  assign line         = line_q;
  assign display_nums = disp_q;
  assign bingo        = bingo_q;
  assign found        = found_q;
  assign done         = (state_q == ST_DONE);

endmodule
